// File: rtl/uart_bcd_frame_decoder.sv
// Parses HEADER/IDX/CNT/digits/CHK frames from a UART byte stream into a
// shadow buffer and commits the addressed BCD channel window only on a good checksum.
module uart_bcd_frame_decoder #(
  parameter int         NUM_CH      = 10,
  parameter logic [7:0] HEADER      = 8'hAA,
  parameter int         TIMEOUT_CYC = 240000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_done,
  output logic [NUM_CH*4-1:0]   bcd_out,
  output logic                  frame_ok,
  output logic                  frame_err,
  output logic [1:0]            err_code,
  output logic                  busy
);

  localparam int IW = $clog2(NUM_CH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  localparam logic [1:0] ERR_RANGE = 2'b00;
  localparam logic [1:0] ERR_BYTE  = 2'b01;
  localparam logic [1:0] ERR_CHK   = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_IDX, S_CNT, S_DATA, S_CHK} state_t;

  state_t                state_q;
  logic [IW-1:0]         idx_q;
  logic [IW-1:0]         cnt_q;
  logic [IW-1:0]         n_q;
  logic [7:0]            xor_q;
  logic [NUM_CH*4-1:0]   shadow_q;
  logic [TW-1:0]         tmo_q;

  logic [7:0]            room;
  logic [IW-1:0]         pos;
  logic [IW-1:0]         n_inc;
  logic [IW-1:0]         win_end;
  logic                  tmo_hit;
  logic                  resync;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  function automatic logic cnt_valid(input logic [7:0] b, input logic [7:0] lim);
    return (b != 8'd0) && (b <= lim);
  endfunction

  assign room    = 8'(NUM_CH) - 8'(idx_q);
  assign pos     = idx_q + n_q;
  assign n_inc   = n_q + IW'(1);
  assign win_end = idx_q + cnt_q;
  // Fires on the edge where the counter would reach TIMEOUT_CYC-1; a byte in that cycle wins.
  assign tmo_hit = (state_q != S_IDLE) && (tmo_q == TW'(TIMEOUT_CYC - 2));
  assign resync  = (rx_data == HEADER) &&
                   ((state_q == S_IDX) || (state_q == S_CNT) || (state_q == S_DATA));
  assign busy    = (state_q != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      n_q       <= '0;
      xor_q     <= '0;
      shadow_q  <= '0;
      bcd_out   <= '0;
      tmo_q     <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_RANGE;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      if ((state_q == S_IDLE) || rx_done) tmo_q <= '0;
      else                                tmo_q <= tmo_q + TW'(1);

      if (rx_done) begin
        if (resync) begin
          frame_err <= 1'b1;
          err_code  <= ERR_BYTE;
          xor_q     <= '0;
          state_q   <= S_IDX;
        end else begin
          case (state_q)
            S_IDLE: begin
              if (rx_data == HEADER) begin
                xor_q   <= '0;
                state_q <= S_IDX;
              end
            end
            S_IDX: begin
              if (rx_data < 8'(NUM_CH)) begin
                idx_q   <= rx_data[IW-1:0];
                xor_q   <= rx_data;
                state_q <= S_CNT;
              end else begin
                frame_err <= 1'b1;
                err_code  <= ERR_RANGE;
                state_q   <= S_IDLE;
              end
            end
            S_CNT: begin
              if (cnt_valid(rx_data, room)) begin
                cnt_q   <= rx_data[IW-1:0];
                n_q     <= '0;
                xor_q   <= xor_q ^ rx_data;
                state_q <= S_DATA;
              end else begin
                frame_err <= 1'b1;
                err_code  <= ERR_RANGE;
                state_q   <= S_IDLE;
              end
            end
            S_DATA: begin
              if (is_digit(rx_data)) begin
                for (int k = 0; k < NUM_CH; k++) begin
                  if (pos == IW'(k)) shadow_q[4*k +: 4] <= rx_data[3:0];
                end
                n_q   <= n_inc;
                xor_q <= xor_q ^ rx_data;
                if (n_inc == cnt_q) state_q <= S_CHK;
              end else begin
                frame_err <= 1'b1;
                err_code  <= ERR_BYTE;
                state_q   <= S_IDLE;
              end
            end
            S_CHK: begin
              if (rx_data == xor_q) begin
                for (int k = 0; k < NUM_CH; k++) begin
                  if ((IW'(k) >= idx_q) && (IW'(k) < win_end))
                    bcd_out[4*k +: 4] <= shadow_q[4*k +: 4];
                end
                frame_ok <= 1'b1;
              end else begin
                frame_err <= 1'b1;
                err_code  <= ERR_CHK;
              end
              state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
          endcase
        end
      end else if (tmo_hit) begin
        frame_err <= 1'b1;
        err_code  <= ERR_TMO;
        state_q   <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_bcd_frame_decoder.sv
// Directed and randomized frames checked against a channel-array model of the display.
module tb_uart_bcd_frame_decoder;

  localparam int         NUM_CH      = 10;
  localparam int         TIMEOUT_CYC = 100;
  localparam logic [7:0] HDR         = 8'hAA;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [7:0]           rx_data;
  logic                 rx_done;
  logic [NUM_CH*4-1:0]  bcd_out;
  logic                 frame_ok;
  logic                 frame_err;
  logic [1:0]           err_code;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_d [NUM_CH];
  logic [1:0] exp_code;
  logic [3:0] dig   [NUM_CH];

  uart_bcd_frame_decoder #(
    .NUM_CH(NUM_CH), .HEADER(HDR), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .bcd_out(bcd_out), .frame_ok(frame_ok), .frame_err(frame_err),
    .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_CH*4-1:0] model_vec();
    logic [NUM_CH*4-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_CH; k++) v[4*k +: 4] = exp_d[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) exp_d[k] = 4'd0;
    exp_code = 2'b00;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_end(input string tag, input bit ok, input bit err, input bit bsy);
    chk({tag, ".frame_ok"},  frame_ok,  ok);
    chk({tag, ".frame_err"}, frame_err, err);
    chk({tag, ".err_code"},  err_code,  exp_code);
    chk({tag, ".bcd_out"},   bcd_out,   model_vec());
    chk({tag, ".busy"},      busy,      bsy);
    idle(1);
    chk({tag, ".ok_pulse"},  frame_ok,  1'b0);
    chk({tag, ".err_pulse"}, frame_err, 1'b0);
  endtask

  task automatic random_frame(input int it);
    int idx, cnt, kind, bad;
    logic [7:0] x, b;
    bit aborted;
    string tag;
    tag = $sformatf("rnd%0d", it);
    idx  = $urandom_range(0, NUM_CH - 1);
    cnt  = $urandom_range(1, NUM_CH - idx);
    kind = $urandom_range(0, 4);
    for (int i = 0; i < NUM_CH; i++) dig[i] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 3) == 0) begin
      send(8'($urandom_range(0, 8'hA9)));
      chk({tag, ".junk_err"},  frame_err, 1'b0);
      chk({tag, ".junk_busy"}, busy,      1'b0);
    end
    send(HDR);
    idle($urandom_range(0, 3));
    send(8'(idx));
    idle($urandom_range(0, 3));
    if (kind == 4) begin
      send(8'(NUM_CH - idx + 1 + $urandom_range(0, 40)));
      exp_code = 2'b00;
      expect_end({tag, ".range"}, 1'b0, 1'b1, 1'b0);
    end else begin
      send(8'(cnt));
      x = 8'(idx) ^ 8'(cnt);
      bad = (kind == 3) ? $urandom_range(0, cnt - 1) : -1;
      aborted = 1'b0;
      for (int i = 0; i < cnt; i++) begin
        if (!aborted) begin
          idle($urandom_range(0, 3));
          if (i == bad) begin
            send(8'($urandom_range(8'h3A, 8'hA9)));
            exp_code = 2'b01;
            expect_end({tag, ".badbyte"}, 1'b0, 1'b1, 1'b0);
            aborted = 1'b1;
          end else begin
            b = 8'h30 | {4'h0, dig[i]};
            x = x ^ b;
            send(b);
          end
        end
      end
      if (!aborted) begin
        idle($urandom_range(0, 3));
        if (kind == 2) begin
          send(x ^ 8'($urandom_range(1, 255)));
          exp_code = 2'b10;
          expect_end({tag, ".chkerr"}, 1'b0, 1'b1, 1'b0);
        end else begin
          send(x);
          for (int i = 0; i < cnt; i++) exp_d[idx + i] = dig[i];
          expect_end({tag, ".commit"}, 1'b1, 1'b0, 1'b0);
        end
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    model_reset();
    #12;
    chk("reset.bcd_out",   bcd_out,   '0);
    chk("reset.frame_ok",  frame_ok,  1'b0);
    chk("reset.frame_err", frame_err, 1'b0);
    chk("reset.err_code",  err_code,  2'b00);
    chk("reset.busy",      busy,      1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // Valid frame writing channels 2..4
    send(8'hAA); send(8'h02); send(8'h03);
    send(8'h31); send(8'h32); send(8'h33);
    chk("t1.busy_mid", busy, 1'b1);
    send(8'h31);
    exp_d[2] = 4'd1; exp_d[3] = 4'd2; exp_d[4] = 4'd3;
    expect_end("t1", 1'b1, 1'b0, 1'b0);

    // Checksum error, then last-channel frame
    send(8'hAA); send(8'h02); send(8'h03);
    send(8'h31); send(8'h32); send(8'h33); send(8'h30);
    exp_code = 2'b10;
    expect_end("t2.chk", 1'b0, 1'b1, 1'b0);
    send(8'hAA); send(8'h09); send(8'h01); send(8'h35); send(8'h3D);
    exp_d[9] = 4'd5;
    expect_end("t2.ch9", 1'b1, 1'b0, 1'b0);

    // Range errors on CNT and IDX
    send(8'hAA); send(8'h08); send(8'h03);
    exp_code = 2'b00;
    expect_end("t3.cnt", 1'b0, 1'b1, 1'b0);
    send(8'hAA); send(8'h0A);
    expect_end("t3.idx", 1'b0, 1'b1, 1'b0);

    // Bad byte, then resync on a header inside the frame
    send(8'hAA); send(8'h00); send(8'h02); send(8'h34); send(8'h41);
    exp_code = 2'b01;
    expect_end("t4.bad", 1'b0, 1'b1, 1'b0);
    send(8'hAA); send(8'h00); send(8'hAA);
    expect_end("t4.resync", 1'b0, 1'b1, 1'b1);
    send(8'h00); send(8'h01); send(8'h37); send(8'h36);
    exp_d[0] = 4'd7;
    expect_end("t4.commit", 1'b1, 1'b0, 1'b0);

    // Timeout exactly 99 cycles after the last strobe
    send(8'hAA); send(8'h01);
    idle(98);
    chk("t5.no_err_early", frame_err, 1'b0);
    chk("t5.busy_early",   busy,      1'b1);
    idle(1);
    exp_code = 2'b11;
    expect_end("t5.tmo", 1'b0, 1'b1, 1'b0);

    // Strobe coinciding with expiry is accepted
    send(8'hAA); send(8'h01);
    idle(98);
    send(8'h01);
    chk("t5b.no_err", frame_err, 1'b0);
    chk("t5b.busy",   busy,      1'b1);
    send(8'h32); send(8'h32);
    exp_d[1] = 4'd2;
    expect_end("t5b.commit", 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-frame
    send(8'hAA); send(8'h00); send(8'h03); send(8'h31);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("t6.bcd_out",  bcd_out,  '0);
    chk("t6.busy",     busy,     1'b0);
    chk("t6.err_code", err_code, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    send(8'hAA); send(8'h00); send(8'h01); send(8'h39); send(8'h38);
    exp_d[0] = 4'd9;
    expect_end("t6.commit", 1'b1, 1'b0, 1'b0);

    for (int it = 0; it < 40; it++) random_frame(it);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
